// File: rtl/aes_masked_req_ctrl.sv
// Request/response front end for aes_masked_core: latches a job, refreshes
// 384 bits of mask randomness from a Galois LFSR, runs the core handshake.
package aes_masked_req_pkg;
  typedef enum logic [1:0] {AES_128 = 2'd0, AES_192 = 2'd1, AES_256 = 2'd2} key_size_e;
endpackage

module aes_masked_req_ctrl
  import aes_masked_req_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter logic [63:0] LFSR_SEED      = 64'hACE1_0F0F_1234_5678
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_enc_dec_i,
  input  key_size_e     req_key_size_i,
  input  logic [127:0]  req_pt_i,
  input  logic [255:0]  req_key_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [127:0]  rsp_data_o,
  output logic          rsp_err_o,
  output logic [15:0]   rsp_cycles_o,
  input  logic          reseed_i,
  input  logic [63:0]   seed_i,
  output logic          core_start_o,
  output logic          core_enc_dec_o,
  output key_size_e     core_key_size_o,
  output logic [127:0]  core_pt_o,
  output logic [255:0]  core_key_o,
  output logic [127:0]  core_pt_rand_o,
  output logic [255:0]  core_key_rand_o,
  input  logic          core_busy_i,
  input  logic          core_done_i,
  input  logic          core_valid_i,
  input  logic [127:0]  core_ct_i
);
  // x^64 + x^63 + x^61 + x^60 + 1, right-shifting Galois form
  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_START, S_WAIT, S_RESP} state_e;

  state_e       state_q, state_d;
  logic [63:0]  lfsr_q, lfsr_d, lfsr_next;
  logic [383:0] rand_q, rand_d;
  logic [2:0]   gen_cnt_q, gen_cnt_d;
  logic [15:0]  cnt_q, cnt_d, cnt_inc;
  logic         enc_q, enc_d;
  key_size_e    ks_q, ks_d;
  logic [127:0] pt_q, pt_d;
  logic [255:0] key_q, key_d;
  logic [127:0] rdata_q, rdata_d;
  logic         rerr_q, rerr_d;
  logic [15:0]  rcyc_q, rcyc_d;

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    rand_d       = rand_q;
    gen_cnt_d    = gen_cnt_q;
    cnt_d        = cnt_q;
    enc_d        = enc_q;
    ks_d         = ks_q;
    pt_d         = pt_q;
    key_d        = key_q;
    rdata_d      = rdata_q;
    rerr_d       = rerr_q;
    rcyc_d       = rcyc_q;
    core_start_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        // reseed lands before GEN, so a job accepted this cycle uses the new seed
        if (reseed_i) lfsr_d = (seed_i == 64'd0) ? LFSR_SEED : seed_i;
        if (req_valid_i) begin
          enc_d     = req_enc_dec_i;
          ks_d      = req_key_size_i;
          pt_d      = req_pt_i;
          key_d     = req_key_i;
          gen_cnt_d = 3'd0;
          state_d   = S_GEN;
        end
      end
      S_GEN: begin
        lfsr_d    = lfsr_next;
        rand_d    = {rand_q[319:0], lfsr_next};
        gen_cnt_d = gen_cnt_q + 3'd1;
        if (gen_cnt_q == 3'd5) state_d = S_START;
      end
      S_START: begin
        if (!core_busy_i) begin
          core_start_o = 1'b1;
          cnt_d        = 16'd0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        // cnt_inc counts this WAIT cycle, so done on the first one reports 1
        cnt_d = cnt_inc;
        if (core_done_i) begin
          rdata_d = core_valid_i ? core_ct_i : 128'd0;
          rerr_d  = !core_valid_i;
          rcyc_d  = cnt_inc;
          state_d = S_RESP;
        end else if (cnt_inc == TIMEOUT_W) begin
          rdata_d = 128'd0;
          rerr_d  = 1'b1;
          rcyc_d  = cnt_inc;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      rand_q    <= '0;
      gen_cnt_q <= '0;
      cnt_q     <= '0;
      enc_q     <= 1'b0;
      ks_q      <= AES_128;
      pt_q      <= '0;
      key_q     <= '0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      rcyc_q    <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      rand_q    <= rand_d;
      gen_cnt_q <= gen_cnt_d;
      cnt_q     <= cnt_d;
      enc_q     <= enc_d;
      ks_q      <= ks_d;
      pt_q      <= pt_d;
      key_q     <= key_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      rcyc_q    <= rcyc_d;
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign rsp_valid_o     = (state_q == S_RESP);
  assign rsp_data_o      = rdata_q;
  assign rsp_err_o       = rerr_q;
  assign rsp_cycles_o    = rcyc_q;
  assign core_enc_dec_o  = enc_q;
  assign core_key_size_o = ks_q;
  assign core_pt_o       = pt_q;
  assign core_key_o      = key_q;
  assign core_pt_rand_o  = rand_q[383:256];
  assign core_key_rand_o = rand_q[255:0];
endmodule

// File: tb/tb_aes_masked_req_ctrl.sv
// Randomized job-level bench for aes_masked_req_ctrl with a stub core and a
// timeline model of the expected outputs derived from the block's rules.
module tb_aes_masked_req_ctrl;
  import aes_masked_req_pkg::*;

  localparam int          TO   = 20;
  localparam logic [63:0] SEED = 64'hACE1_0F0F_1234_5678;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid_i, req_ready_o, req_enc_dec_i;
  key_size_e req_key_size_i;
  logic [127:0] req_pt_i;
  logic [255:0] req_key_i;
  logic rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [127:0] rsp_data_o;
  logic [15:0] rsp_cycles_o;
  logic reseed_i;
  logic [63:0] seed_i;
  logic core_start_o, core_enc_dec_o;
  key_size_e core_key_size_o;
  logic [127:0] core_pt_o, core_pt_rand_o;
  logic [255:0] core_key_o, core_key_rand_o;
  logic core_busy_i, core_done_i, core_valid_i;
  logic [127:0] core_ct_i;

  always #5 clk = ~clk;

  aes_masked_req_ctrl #(.TIMEOUT_CYCLES(TO), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_enc_dec_i(req_enc_dec_i),
    .req_key_size_i(req_key_size_i), .req_pt_i(req_pt_i), .req_key_i(req_key_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .rsp_cycles_o(rsp_cycles_o),
    .reseed_i(reseed_i), .seed_i(seed_i),
    .core_start_o(core_start_o), .core_enc_dec_o(core_enc_dec_o),
    .core_key_size_o(core_key_size_o), .core_pt_o(core_pt_o), .core_key_o(core_key_o),
    .core_pt_rand_o(core_pt_rand_o), .core_key_rand_o(core_key_rand_o),
    .core_busy_i(core_busy_i), .core_done_i(core_done_i), .core_valid_i(core_valid_i),
    .core_ct_i(core_ct_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model state
  logic [63:0]  m_lfsr;
  bit           chk_en = 1'b0;
  logic         e_ready, e_start, e_rvalid, e_err, e_enc;
  key_size_e    e_ks;
  logic [127:0] e_data, e_pt, e_ptr;
  logic [255:0] e_key, e_keyr;
  logic [15:0]  e_cyc;
  bit           e_rand_chk;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    int taps[4] = '{64, 63, 61, 60};
    logic [63:0] poly = '0;
    foreach (taps[i]) poly[taps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

  task automatic model_gen();
    logic [63:0] w[6];
    for (int i = 0; i < 6; i++) begin
      m_lfsr = lfsr_step(m_lfsr);
      w[i] = m_lfsr;
    end
    e_ptr  = {w[0], w[1]};
    e_keyr = {w[2], w[3], w[4], w[5]};
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("req_ready", 256'(req_ready_o), 256'(e_ready));
      chk("core_start", 256'(core_start_o), 256'(e_start));
      chk("rsp_valid", 256'(rsp_valid_o), 256'(e_rvalid));
      chk("core_enc_dec", 256'(core_enc_dec_o), 256'(e_enc));
      chk("core_key_size", 256'(core_key_size_o), 256'(e_ks));
      chk("core_pt", 256'(core_pt_o), 256'(e_pt));
      chk("core_key", core_key_o, e_key);
      if (e_rvalid) begin
        chk("rsp_data", 256'(rsp_data_o), 256'(e_data));
        chk("rsp_err", 256'(rsp_err_o), 256'(e_err));
        chk("rsp_cycles", 256'(rsp_cycles_o), 256'(e_cyc));
      end
      if (e_rand_chk) begin
        chk("core_pt_rand", 256'(core_pt_rand_o), 256'(e_ptr));
        chk("core_key_rand", core_key_rand_o, e_keyr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    core_done_i = 1'b0; req_valid_i = 1'b0; reseed_i = 1'b0; core_busy_i = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_req_ready", 256'(req_ready_o), 256'(1));
    chk("rst_rsp_valid", 256'(rsp_valid_o), 256'(0));
    chk("rst_core_start", 256'(core_start_o), 256'(0));
    chk("rst_core_pt", 256'(core_pt_o), 256'(0));
    chk("rst_core_key_rand", core_key_rand_o, 256'(0));
    m_lfsr = SEED;
    e_enc = 1'b0; e_ks = AES_128; e_pt = '0; e_key = '0; e_ptr = '0; e_keyr = '0;
    e_rand_chk = 1'b1; e_ready = 1'b1; e_start = 1'b0; e_rvalid = 1'b0;
    e_data = '0; e_err = 1'b0; e_cyc = '0;
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic idle(input bit rs, input logic [63:0] sd);
    req_valid_i = 1'b0; reseed_i = rs; seed_i = sd;
    e_ready = 1'b1; e_start = 1'b0; e_rvalid = 1'b0;
    tick();
    if (rs) m_lfsr = (sd == 64'd0) ? SEED : sd;
    reseed_i = 1'b0;
  endtask

  // one job: dly = WAIT cycle carrying done (beyond TO means never), abort_at>0 resets there
  task automatic run_job(input bit rs, input logic [63:0] sd, input int busy_n, input int dly,
                         input bit cv, input int hold, input int abort_at);
    logic ne;
    key_size_e nks;
    logic [127:0] npt, nct;
    logic [255:0] nkey;
    ne   = 1'($urandom_range(0, 1));
    nks  = key_size_e'($urandom_range(0, 2));
    npt  = {$urandom, $urandom, $urandom, $urandom};
    nct  = {$urandom, $urandom, $urandom, $urandom};
    nkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_valid_i = 1'b1; req_enc_dec_i = ne; req_key_size_i = nks; req_pt_i = npt; req_key_i = nkey;
    reseed_i = rs; seed_i = sd;
    core_busy_i = 1'b0; core_done_i = 1'b0; rsp_ready_i = 1'($urandom);
    e_ready = 1'b1; e_start = 1'b0; e_rvalid = 1'b0;
    tick();
    if (rs) m_lfsr = (sd == 64'd0) ? SEED : sd;
    e_enc = ne; e_ks = nks; e_pt = npt; e_key = nkey; e_rand_chk = 1'b0; e_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid_i = 1'($urandom); reseed_i = 1'($urandom); seed_i = {$urandom, $urandom};
      req_pt_i = {$urandom, $urandom, $urandom, $urandom};
      core_done_i = 1'($urandom); core_valid_i = 1'($urandom);
      tick();
    end
    model_gen();
    e_rand_chk = 1'b1;
    core_done_i = 1'b0;
    for (int i = 0; i < busy_n; i++) begin
      core_busy_i = 1'b1; e_start = 1'b0;
      tick();
    end
    core_busy_i = 1'b0; e_start = 1'b1;
    tick();
    e_start = 1'b0; core_busy_i = 1'b1;
    for (int k = 1; k <= dly && k <= TO; k++) begin
      if (k == abort_at) begin
        do_reset();
        return;
      end
      core_done_i  = (k == dly);
      core_valid_i = (k == dly) ? cv : 1'($urandom);
      core_ct_i    = (k == dly) ? nct : {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    core_done_i = 1'($urandom); core_busy_i = 1'b0;
    e_rvalid = 1'b1;
    if (dly <= TO) begin
      e_err = !cv; e_data = cv ? nct : 128'd0; e_cyc = 16'(dly);
    end else begin
      e_err = 1'b1; e_data = 128'd0; e_cyc = 16'(TO);
    end
    for (int i = 0; i < hold; i++) begin
      rsp_ready_i = 1'b0; req_valid_i = 1'($urandom);
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0; reseed_i = 1'b0; core_done_i = 1'b0;
    e_rvalid = 1'b0; e_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid_i = 1'b0; req_enc_dec_i = 1'b0; req_key_size_i = AES_128; req_pt_i = '0;
    req_key_i = '0; rsp_ready_i = 1'b0; reseed_i = 1'b0; seed_i = '0;
    core_busy_i = 1'b0; core_done_i = 1'b0; core_valid_i = 1'b0; core_ct_i = '0;
    m_lfsr = SEED;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_rsp_data", 256'(rsp_data_o), 256'(0));
    chk("rst_rsp_cycles", 256'(rsp_cycles_o), 256'(0));

    run_job(1'b0, 64'd0, 0, 5, 1'b1, 0, 0);
    // seed 1: every step shifts right except the first, which applies the tap mask
    run_job(1'b1, 64'd1, 0, 7, 1'b1, 2, 0);
    chk("seed1_pt_rand", 256'(core_pt_rand_o), 256'({64'hD800_0000_0000_0000, 64'h6C00_0000_0000_0000}));
    chk("seed1_key_rand", core_key_rand_o, {64'h3600_0000_0000_0000, 64'h1B00_0000_0000_0000,
                                            64'h0D80_0000_0000_0000, 64'h06C0_0000_0000_0000});
    run_job(1'b1, 64'd1, 0, 3, 1'b1, 0, 0);
    chk("seed1_again_pt_rand", 256'(core_pt_rand_o), 256'({64'hD800_0000_0000_0000, 64'h6C00_0000_0000_0000}));
    run_job(1'b1, 64'd0, 0, 4, 1'b1, 0, 0);
    chk("seed0_first_word", 256'(core_pt_rand_o[127:64]), 256'(64'h5670_8787_891A_2B3C));

    run_job(1'b0, 64'd0, 0, 6, 1'b1, 10, 0);     // response held 10 cycles
    run_job(1'b0, 64'd0, 0, 1000, 1'b1, 1, 0);   // never done: timeout
    run_job(1'b0, 64'd0, 0, TO, 1'b1, 0, 0);     // done on the timeout cycle
    run_job(1'b0, 64'd0, 0, TO - 1, 1'b1, 0, 0);
    run_job(1'b0, 64'd0, 0, 2, 1'b0, 0, 0);      // core_valid low at done
    run_job(1'b0, 64'd0, 3, 1, 1'b1, 0, 0);      // core busy delays start
    idle(1'b1, {$urandom, $urandom});
    idle(1'b0, 64'd0);
    run_job(1'b0, 64'd0, 0, 9, 1'b1, 0, 0);
    run_job(1'b0, 64'd0, 0, 10, 1'b1, 0, 4);     // reset mid-WAIT
    run_job(1'b0, 64'd0, 0, 8, 1'b1, 1, 0);

    for (int j = 0; j < 30; j++) begin
      int nidle;
      bit rs;
      logic [63:0] sd;
      nidle = $urandom_range(0, 2);
      for (int i = 0; i < nidle; i++) idle(($urandom_range(0, 3) == 0), {$urandom, $urandom});
      rs = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      run_job(rs, sd, $urandom_range(0, 3), $urandom_range(1, TO + 4),
              ($urandom_range(0, 4) != 0), $urandom_range(0, 3), 0);
    end
    idle(1'b0, 64'd0);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
